// File: rtl/alarm_pkg.sv
// Shared types, field limits and helpers for the multi-channel alarm bank.
package alarm_pkg;

    typedef enum logic [1:0] {A_IDLE, A_RINGING, A_SNOOZED} alarm_state_e;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_SEC  = 6'd59;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
    } hms_t;

    // Field increment with wrap and no carry; out-of-range values also wrap to 0.
    function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max_v);
        return (v >= max_v) ? 6'd0 : v + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored time, armed flag, ring/snooze FSM with timeout and snooze limit.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SECS   = 10,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic match_i,
    input  logic wr_i,
    input  hms_t wr_time_i,
    input  logic toggle_i,
    input  logic snooze_i,
    input  logic stop_i,
    output hms_t stored_o,
    output logic armed_o,
    output logic ringing_o
);
    localparam int unsigned UW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [7:0]  RING_LAST = 8'(RING_SECS - 1);
    localparam logic [9:0]  SNZ_LAST  = 10'(SNOOZE_SECS - 1);
    localparam logic [UW-1:0] SNZ_MAX = UW'(MAX_SNOOZE);

    alarm_state_e  state_q;
    hms_t          stored_q;
    logic          armed_q;
    logic          ringing_q;
    logic [7:0]    ring_cnt_q;
    logic [9:0]    snz_cnt_q;
    logic [UW-1:0] snz_used_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= A_IDLE;
            stored_q   <= '0;
            armed_q    <= 1'b0;
            ringing_q  <= 1'b0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            snz_used_q <= '0;
        end else begin
            if (wr_i) begin
                stored_q <= wr_time_i;
                armed_q  <= 1'b1;
            end else if (toggle_i) begin
                armed_q <= ~armed_q;
            end
            // Saving, disarming and stop all silence the channel and outrank any match/snooze.
            if (wr_i || (toggle_i && armed_q) || (stop_i && state_q != A_IDLE)) begin
                state_q   <= A_IDLE;
                ringing_q <= 1'b0;
            end else begin
                unique case (state_q)
                    A_IDLE: begin
                        if (match_i) begin
                            state_q    <= A_RINGING;
                            ringing_q  <= 1'b1;
                            ring_cnt_q <= '0;
                            snz_used_q <= '0;
                        end
                    end
                    A_RINGING: begin
                        if (snooze_i) begin
                            ringing_q <= 1'b0;
                            if (snz_used_q < SNZ_MAX) begin
                                state_q    <= A_SNOOZED;
                                snz_cnt_q  <= '0;
                                snz_used_q <= snz_used_q + 1'b1;
                            end else begin
                                state_q <= A_IDLE;
                            end
                        end else if (tick_i) begin
                            if (match_i) begin
                                ring_cnt_q <= '0;
                            end else if (ring_cnt_q == RING_LAST) begin
                                state_q   <= A_IDLE;
                                ringing_q <= 1'b0;
                            end else begin
                                ring_cnt_q <= ring_cnt_q + 1'b1;
                            end
                        end
                    end
                    A_SNOOZED: begin
                        if (tick_i) begin
                            if (snz_cnt_q == SNZ_LAST) begin
                                state_q    <= A_RINGING;
                                ringing_q  <= 1'b1;
                                ring_cnt_q <= '0;
                            end else begin
                                snz_cnt_q <= snz_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q   <= A_IDLE;
                        ringing_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stored_o  = stored_q;
    assign armed_o   = armed_q;
    assign ringing_o = ringing_q;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm bank: strobe edge detection, shared edit buffer, channel decode and LED.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned RING_SECS   = 10,
    parameter int unsigned SNOOZE_SECS = 300,
    parameter int unsigned MAX_SNOOZE  = 3,
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            CP_1KHz,
    input  logic            CR,
    input  logic            tick_1Hz,
    input  logic [4:0]      hours_24,
    input  logic [5:0]      minutes,
    input  logic [5:0]      seconds,
    input  logic [CW-1:0]   sel_ch,
    input  logic            edit_en,
    input  logic            inc_hour,
    input  logic            inc_min,
    input  logic            inc_sec,
    input  logic            save,
    input  logic            arm_toggle,
    input  logic            snooze,
    input  logic            stop,
    output logic [4:0]      edit_hours,
    output logic [5:0]      edit_min,
    output logic [5:0]      edit_sec,
    output logic [N_CH-1:0] armed,
    output logic [N_CH-1:0] ringing,
    output logic            alarm_led
);
    logic [6:0] strobe, strobe_q, rise;
    logic       inc_h, inc_m, inc_s, save_p, tog_p, snooze_p, stop_p;

    assign strobe   = {inc_hour, inc_min, inc_sec, save, arm_toggle, snooze, stop};
    assign rise     = strobe & ~strobe_q;
    assign inc_h    = edit_en & rise[6];
    assign inc_m    = edit_en & rise[5];
    assign inc_s    = edit_en & rise[4];
    assign save_p   = edit_en & rise[3];
    assign tog_p    = edit_en & rise[2];
    assign snooze_p = rise[1];
    assign stop_p   = rise[0];

    hms_t          edit_q, edit_d, now, load_val;
    hms_t          stored [N_CH];
    logic [CW-1:0] sel_q;
    logic          sel_hit;
    logic [N_CH-1:0] match, wr, tog;

    assign now = {hours_24, minutes, seconds};

    always_comb begin
        load_val = '0;
        sel_hit  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel_ch == CW'(i)) begin
                load_val = stored[i];
                sel_hit  = 1'b1;
            end
        end
        edit_d = edit_q;
        if (sel_ch != sel_q) begin
            if (sel_hit) edit_d = load_val;
        end else begin
            if (inc_h) edit_d.hour = 5'(inc_wrap({1'b0, edit_q.hour}, {1'b0, MAX_HOUR}));
            if (inc_m) edit_d.min  = inc_wrap(edit_q.min, MAX_MIN);
            if (inc_s) edit_d.sec  = inc_wrap(edit_q.sec, MAX_SEC);
        end
    end

    always_ff @(posedge CP_1KHz or posedge CR) begin
        if (CR) begin
            strobe_q <= '0;
            sel_q    <= '0;
            edit_q   <= '0;
        end else begin
            strobe_q <= strobe;
            sel_q    <= sel_ch;
            edit_q   <= edit_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic sel_this;
        assign sel_this = (sel_ch == CW'(g));
        assign wr[g]    = save_p & sel_this;
        assign tog[g]   = tog_p & sel_this;
        assign match[g] = tick_1Hz & armed[g] & (stored[g] == now);

        alarm_channel #(
            .RING_SECS  (RING_SECS),
            .SNOOZE_SECS(SNOOZE_SECS),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_ch (
            .clk_i    (CP_1KHz),
            .rst_i    (CR),
            .tick_i   (tick_1Hz),
            .match_i  (match[g]),
            .wr_i     (wr[g]),
            .wr_time_i(edit_q),
            .toggle_i (tog[g]),
            .snooze_i (snooze_p),
            .stop_i   (stop_p),
            .stored_o (stored[g]),
            .armed_o  (armed[g]),
            .ringing_o(ringing[g])
        );
    end

    assign edit_hours = edit_q.hour;
    assign edit_min   = edit_q.min;
    assign edit_sec   = edit_q.sec;
    // OR of per-channel ringing flops, so the LED tracks channel state with no added cycle.
    assign alarm_led  = |ringing;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: editing, ring timeout, snooze limit, concurrency, disarm, reset.
module tb_alarm_bank;
    // Five channels so a 3-bit sel_ch can address a channel that does not exist.
    localparam int unsigned NCH = 5;

    localparam logic [6:0] P_HOUR = 7'b1000000;
    localparam logic [6:0] P_MIN  = 7'b0100000;
    localparam logic [6:0] P_SEC  = 7'b0010000;
    localparam logic [6:0] P_SAVE = 7'b0001000;
    localparam logic [6:0] P_ARM  = 7'b0000100;
    localparam logic [6:0] P_SNZ  = 7'b0000010;
    localparam logic [6:0] P_STOP = 7'b0000001;

    logic clk = 1'b0;
    logic rst;
    logic tick_1Hz;
    logic [4:0] cur_h;
    logic [5:0] cur_m, cur_s;
    logic [2:0] sel_ch;
    logic edit_en, inc_hour, inc_min, inc_sec, save, arm_toggle, snooze, stop;
    logic [4:0] edit_hours;
    logic [5:0] edit_min, edit_sec;
    logic [NCH-1:0] armed, ringing;
    logic alarm_led;

    int tests = 0;
    int fails = 0;

    alarm_bank #(
        .N_CH       (NCH),
        .RING_SECS  (10),
        .SNOOZE_SECS(300),
        .MAX_SNOOZE (3)
    ) dut (
        .CP_1KHz   (clk),
        .CR        (rst),
        .tick_1Hz  (tick_1Hz),
        .hours_24  (cur_h),
        .minutes   (cur_m),
        .seconds   (cur_s),
        .sel_ch    (sel_ch),
        .edit_en   (edit_en),
        .inc_hour  (inc_hour),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .save      (save),
        .arm_toggle(arm_toggle),
        .snooze    (snooze),
        .stop      (stop),
        .edit_hours(edit_hours),
        .edit_min  (edit_min),
        .edit_sec  (edit_sec),
        .armed     (armed),
        .ringing   (ringing),
        .alarm_led (alarm_led)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [6:0] m);
        {inc_hour, inc_min, inc_sec, save, arm_toggle, snooze, stop} = m;
        step();
        {inc_hour, inc_min, inc_sec, save, arm_toggle, snooze, stop} = '0;
        step();
    endtask

    task automatic press_n(input logic [6:0] m, input int n);
        for (int i = 0; i < n; i++) press(m);
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_h = h;
        cur_m = m;
        cur_s = s;
    endtask

    // One-cycle tick at the presented time, then the clock moves on one second.
    task automatic tick();
        tick_1Hz = 1'b1;
        step();
        tick_1Hz = 1'b0;
        if (cur_s == 6'd59) begin
            cur_s = 6'd0;
            if (cur_m == 6'd59) begin
                cur_m = 6'd0;
                cur_h = (cur_h == 5'd23) ? 5'd0 : cur_h + 5'd1;
            end else begin
                cur_m = cur_m + 6'd1;
            end
        end else begin
            cur_s = cur_s + 6'd1;
        end
        step();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1;
        tick_1Hz = 1'b0;
        sel_ch = 3'd0;
        edit_en = 1'b0;
        {inc_hour, inc_min, inc_sec, save, arm_toggle, snooze, stop} = '0;
        set_time(5'd0, 6'd0, 6'd0);
        step();
        step();
        check("reset_armed", 32'(armed), 0);
        check("reset_ringing", 32'(ringing), 0);
        check("reset_led", 32'(alarm_led), 0);
        check("reset_edit_hours", 32'(edit_hours), 0);
        rst = 1'b0;
        edit_en = 1'b1;
        step();

        // Edit buffer wrap, no carry between fields.
        press_n(P_MIN, 5);
        check("edit_min5", 32'(edit_min), 5);
        press_n(P_SEC, 59);
        check("edit_sec59", 32'(edit_sec), 59);
        press(P_SEC);
        check("edit_sec_wrap", 32'(edit_sec), 0);
        check("edit_min_nocarry", 32'(edit_min), 5);
        press_n(P_HOUR, 23);
        check("edit_hour23", 32'(edit_hours), 23);
        press(P_HOUR);
        check("edit_hour_wrap", 32'(edit_hours), 0);
        press(P_HOUR | P_MIN | P_SEC);
        check("edit_multi_h", 32'(edit_hours), 1);
        check("edit_multi_m", 32'(edit_min), 6);
        check("edit_multi_s", 32'(edit_sec), 1);
        inc_sec = 1'b1;
        step();
        step();
        step();
        inc_sec = 1'b0;
        step();
        check("edit_hold_once", 32'(edit_sec), 2);

        // Basic ring on ch1 at 07:30:00.
        sel_ch = 3'd1;
        step();
        check("sel_load_h", 32'(edit_hours), 0);
        check("sel_load_s", 32'(edit_sec), 0);
        press_n(P_HOUR, 7);
        press_n(P_MIN, 30);
        press(P_SAVE);
        check("save_ch1_armed", 32'(armed), 32'h02);
        set_time(5'd7, 6'd29, 6'd58);
        tick();
        tick();
        check("ring_before", 32'(ringing), 0);
        tick();
        check("ring_start", 32'(ringing), 32'h02);
        check("ring_led", 32'(alarm_led), 1);
        tick_n(9);
        check("ring_held", 32'(ringing), 32'h02);
        tick();
        check("ring_timeout", 32'(ringing), 0);
        check("ring_timeout_led", 32'(alarm_led), 0);
        check("armed_persists", 32'(armed), 32'h02);

        // Snooze three times, fourth snooze acts as stop.
        set_time(5'd7, 6'd30, 6'd0);
        tick();
        check("ring_again", 32'(ringing), 32'h02);
        tick_n(3);
        for (int r = 0; r < 3; r++) begin
            press(P_SNZ);
            check("snooze_silent", 32'(ringing), 0);
            tick_n(299);
            check("snooze_hold", 32'(ringing), 0);
            tick();
            check("snooze_rering", 32'(ringing), 32'h02);
        end
        press(P_SNZ);
        check("snooze_limit", 32'(ringing), 0);
        tick_n(300);
        check("snooze_limit_idle", 32'(ringing), 0);

        // Concurrent ring on ch0 and ch2, snooze+stop together.
        sel_ch = 3'd0;
        step();
        press_n(P_HOUR, 12);
        press(P_SAVE);
        check("save_ch0", 32'(armed), 32'h03);
        sel_ch = 3'd2;
        step();
        press_n(P_HOUR, 12);
        press(P_SAVE);
        check("save_ch2", 32'(armed), 32'h07);
        set_time(5'd11, 6'd59, 6'd59);
        tick();
        check("conc_before", 32'(ringing), 0);
        tick();
        check("conc_ring", 32'(ringing), 32'h05);
        press(P_SNZ | P_STOP);
        check("stop_beats_snooze", 32'(ringing), 0);
        check("stop_led", 32'(alarm_led), 0);

        // Disarm a ringing channel.
        set_time(5'd12, 6'd0, 6'd0);
        tick();
        check("reconc_ring", 32'(ringing), 32'h05);
        press(P_ARM);
        check("disarm_ringing", 32'(ringing), 32'h01);
        check("disarm_armed", 32'(armed), 32'h03);
        press(P_STOP);
        check("stop_ch0", 32'(ringing), 0);

        // Out-of-range channel select: no load, no save.
        sel_ch = 3'd5;
        step();
        press(P_SAVE);
        check("sel5_save_ignored", 32'(armed), 32'h03);
        check("sel5_no_load", 32'(edit_hours), 12);

        edit_en = 1'b0;
        press(P_SEC);
        check("edit_en_gate", 32'(edit_sec), 0);
        edit_en = 1'b1;

        // Save with simultaneous increment stores the pre-increment value.
        sel_ch = 3'd3;
        step();
        press(P_SEC);
        press(P_SAVE | P_SEC);
        check("save_inc_edit", 32'(edit_sec), 2);
        check("save_inc_armed", 32'(armed), 32'h0b);
        sel_ch = 3'd4;
        step();
        sel_ch = 3'd3;
        step();
        check("save_pre_inc", 32'(edit_sec), 1);

        // Asynchronous reset in the middle of a ring.
        set_time(5'd12, 6'd0, 6'd0);
        tick();
        check("pre_reset_ring", 32'(ringing), 32'h01);
        rst = 1'b1;
        #1;
        check("async_rst_ringing", 32'(ringing), 0);
        check("async_rst_armed", 32'(armed), 0);
        check("async_rst_led", 32'(alarm_led), 0);
        check("async_rst_edit_sec", 32'(edit_sec), 0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
